// File: rtl/alu_issue.sv
// RV32I issue stage: decodes an instruction into an ALU op plus two operands and
// registers them behind a valid/ready handshake. Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer.
package pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_alu_op;
endpackage

module alu_issue
  import pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output t_alu_op     alu_op,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [31:0] out_rs2_data,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic        out_illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OPIMM  = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } t_opcode;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    t_alu_op     op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } t_entry;

  localparam t_entry ENTRY_RST = '{
    op: ALU_ADD, in1: '0, in2: '0, rs2: '0, pc: RESET_PC, rd: '0, rd_we: 1'b0, illegal: 1'b0
  };

  function automatic t_alu_op f3_op(input logic [2:0] f3);
    t_alu_op op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] u_imm;
  logic [31:0] shamt;

  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd    = in_instr[11:7];
  assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
  assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign u_imm = {in_instr[31:12], 12'b0};
  assign shamt = {27'b0, in_instr[24:20]};

  logic        legal;
  t_alu_op     d_op;
  logic [31:0] d_in1;
  logic [31:0] d_in2;
  logic        d_we;
  t_entry      dec;

  always_comb begin
    legal = 1'b0;
    d_op  = ALU_ADD;
    d_in1 = '0;
    d_in2 = '0;
    d_we  = 1'b0;
    case (in_instr[6:0])
      OPC_OP: begin
        d_in1 = in_rs1_data;
        d_in2 = in_rs2_data;
        d_we  = 1'b1;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          d_op  = f3_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal = 1'b1;
          d_op  = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal = 1'b1;
          d_op  = ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        d_in1 = in_rs1_data;
        d_in2 = i_imm;
        d_we  = 1'b1;
        legal = 1'b1;
        d_op  = f3_op(f3);
        // Only shifts reuse imm[11:5] as funct7; other OP-IMM forms treat it as immediate.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          d_in2 = shamt;
          if (f7 == F7_ALT && f3 == 3'b101) d_op = ALU_SRA;
          else if (f7 != F7_BASE)           legal = 1'b0;
        end
      end
      OPC_LUI: begin
        legal = 1'b1;
        d_in2 = u_imm;
        d_we  = 1'b1;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        d_in1 = in_pc;
        d_in2 = u_imm;
        d_we  = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1;
        d_in1 = in_pc;
        d_in2 = 32'd4;
        d_we  = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000);
        d_in1 = in_pc;
        d_in2 = 32'd4;
        d_we  = 1'b1;
      end
      OPC_LOAD: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
        d_in1 = in_rs1_data;
        d_in2 = i_imm;
        d_we  = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 <= 3'b010);
        d_in1 = in_rs1_data;
        d_in2 = s_imm;
      end
      OPC_BRANCH: begin
        d_in1 = in_rs1_data;
        d_in2 = in_rs2_data;
        case (f3)
          3'b000, 3'b001: begin legal = 1'b1; d_op = ALU_SUB;  end
          3'b100, 3'b101: begin legal = 1'b1; d_op = ALU_SLT;  end
          3'b110, 3'b111: begin legal = 1'b1; d_op = ALU_SLTU; end
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    dec.op      = legal ? d_op  : ALU_ADD;
    dec.in1     = legal ? d_in1 : '0;
    dec.in2     = legal ? d_in2 : '0;
    dec.rs2     = in_rs2_data;
    dec.pc      = in_pc;
    dec.rd      = rd;
    dec.rd_we   = legal && d_we && (rd != 5'd0);
    dec.illegal = !legal;
  end

  t_entry main_q;
  logic   main_valid;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_valid && out_ready;

`ifdef ALU_ISSUE_SKID_EN
  t_entry skid_q;
  logic   skid_valid;

  // in_ready comes straight off a flop, so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= ENTRY_RST;
      skid_q     <= ENTRY_RST;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_xfer || !main_valid) begin
      // Main slot frees this edge: the older skid entry takes priority over new input.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid || out_ready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      main_valid <= 1'b0;
      main_q     <= ENTRY_RST;
    end else if (flush) begin
      main_valid <= 1'b0;
    end else if (in_xfer) begin
      main_q     <= dec;
      main_valid <= 1'b1;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`endif

  assign out_valid    = main_valid;
  assign alu_op       = main_q.op;
  assign alu_in1      = main_q.in1;
  assign alu_in2      = main_q.in2;
  assign out_rs2_data = main_q.rs2;
  assign out_pc       = main_valid ? main_q.pc : RESET_PC;
  assign out_rd       = main_q.rd;
  assign out_rd_we    = main_q.rd_we;
  assign out_illegal  = main_q.illegal;

endmodule
